// File: rtl/tcdm_mem_responder_if.sv
// TCDM request/response bundle shared by an initiator and the memory responder.
// Requests use a req/gnt handshake; responses use a valid/ready handshake.
interface hci_core_intf #(
  parameter int unsigned DW = 288,
  parameter int unsigned AW = 32,
  parameter int unsigned IW = 8
) ();
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] be;
  logic [IW-1:0]   id;
  logic            r_valid;
  logic            r_ready;
  logic [DW-1:0]   r_data;
  logic [IW-1:0]   r_id;

  modport target (
    input  req, add, wen, data, be, id, r_ready,
    output gnt, r_valid, r_data, r_id
  );

  modport initiator (
    output req, add, wen, data, be, id, r_ready,
    input  gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/tcdm_mem_responder.sv
// Word-addressed TCDM memory model: byte-enabled wide writes, in-order read
// responses through a small FIFO, optional periodic grant stalls and counters.
module tcdm_mem_responder #(
  parameter int unsigned DW        = 288,
  parameter int unsigned AW        = 32,
  parameter int unsigned IW        = 8,
  parameter int unsigned N_WORDS   = 1024,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          stall_en_i,
  hci_core_intf.target  tcdm,
  output logic          busy_o,
  output logic [31:0]   n_rd_o,
  output logic [31:0]   n_wr_o
);

  localparam int unsigned NW   = DW / 32;
  localparam int unsigned IDXW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);

  logic [31:0]     mem_q       [N_WORDS];
  logic [DW-1:0]   fifo_data_q [RSP_DEPTH];
  logic [IW-1:0]   fifo_id_q   [RSP_DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      stall_cnt_q, stall_cnt_d;
  logic [31:0]     n_rd_q, n_rd_d;
  logic [31:0]     n_wr_q, n_wr_d;

  logic [IDXW-1:0] base_idx;
  logic [IDXW-1:0] word_idx [NW];
  logic [DW-1:0]   rd_data;
  logic            stall_c, gnt_c, rd_push, wr_en, pop;
  logic            unused_add;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign base_idx   = tcdm.add[IDXW+1:2];
  assign unused_add = ^tcdm.add;

  // Consecutive word indices of the wide access, wrapping modulo N_WORDS
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      word_idx[w] = base_idx + IDXW'(w);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int w = 0; w < NW; w++) begin
      rd_data[w*32 +: 32] = mem_q[word_idx[w]];
    end
  end

  // A slot freed by a pop only becomes usable the cycle after
  assign stall_c = stall_en_i & (stall_cnt_q == 2'd3);
  assign gnt_c   = rst_ni & ~clear_i & tcdm.req & (count_q < CW'(RSP_DEPTH)) & ~stall_c;
  assign rd_push = gnt_c & tcdm.wen;
  assign wr_en   = gnt_c & ~tcdm.wen;
  assign pop     = (count_q != '0) & tcdm.r_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q + 2'd1;
    n_rd_d      = n_rd_q;
    n_wr_d      = n_wr_q;
    if (rd_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (n_rd_q != 32'hFFFF_FFFF) n_rd_d = n_rd_q + 32'd1;
    end
    if (wr_en && (n_wr_q != 32'hFFFF_FFFF)) n_wr_d = n_wr_q + 32'd1;
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(rd_push) - CW'(pop);
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      stall_cnt_d = '0;
      n_rd_d      = '0;
      n_wr_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      n_rd_q      <= '0;
      n_wr_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      n_rd_q      <= n_rd_d;
      n_wr_q      <= n_wr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by count/pointers
  always_ff @(posedge clk_i) begin
    if (rd_push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_id_q[wr_ptr_q]   <= tcdm.id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int w = 0; w < NW; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (tcdm.be[w*4 + b]) begin
            mem_q[word_idx[w]][b*8 +: 8] <= tcdm.data[w*32 + b*8 +: 8];
          end
        end
      end
    end
  end

  assign tcdm.gnt     = gnt_c;
  assign tcdm.r_valid = (count_q != '0);
  assign tcdm.r_data  = fifo_data_q[rd_ptr_q];
  assign tcdm.r_id    = fifo_id_q[rd_ptr_q];
  assign busy_o       = (count_q != '0);
  assign n_rd_o       = n_rd_q;
  assign n_wr_o       = n_wr_q;

endmodule
